// File: rtl/bios_loader_pkg.sv
// Shared definitions for the boot-time BIOS / MEGA ROM copy sequencer.
// Holds the default flash / SD-RAM image locations and sizes, the phase
// enum, the fetch FSM state type and a size-to-word-count helper.
package bios_loader_pkg;

  // Default image placement (byte addresses / byte sizes).
  localparam logic [23:0] FLASH_ADDR_BIOS    = 24'h10_0000;
  localparam logic [23:0] RAM_ADDR_BIOS      = 24'h70_0000;
  localparam logic [23:0] FLASH_SIZE_BIOS    = 24'h02_4000;
  localparam logic [23:0] FLASH_ADDR_MEGAROM = 24'h20_0000;
  localparam logic [23:0] RAM_ADDR_MEGAROM   = 24'h40_0000;
  localparam logic [23:0] FLASH_SIZE_MEGAROM = 24'h20_0000;

  // A 2 MB image is 0x10_0000 words, which needs all 21 bits.
  localparam int unsigned WordCntW = 21;

  typedef enum logic {
    PHASE_BIOS,
    PHASE_MEGA
  } phase_e;

  typedef enum logic [2:0] {
    StIdle,
    StFetchLo,
    StFetchHi,
    StPush,
    StNext,
    StDrain
  } state_e;

  // Byte size to 16-bit word count; sizes are even by construction.
  function automatic logic [WordCntW-1:0] size_to_words(input logic [23:0] size);
    logic [23:0] half;
    half = size >> 1;
    return half[WordCntW-1:0];
  endfunction

endpackage

// File: rtl/bios_loader_word_pack_buf.sv
// Byte-to-word packer plus single-entry write buffer for bios_loader.
// Ports:
//   clk_i, reset_i   : clock, synchronous active-high reset
//   lo_we_i, hi_we_i : capture byte_i as the even / odd byte of the word
//   byte_i           : flash read byte
//   push_i           : load {hi, lo} and push_addr_i into the buffer
//   push_addr_i      : SD-RAM byte address of the word being pushed
//   ready_o          : buffer can take a push this cycle
//   valid_o          : buffer holds a word not yet acknowledged
//   ram_wr_o, ram_addr_o, ram_wdata_o, ram_ack_i : SD-RAM write handshake
module bios_loader_word_pack_buf (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        lo_we_i,
  input  logic        hi_we_i,
  input  logic [7:0]  byte_i,
  input  logic        push_i,
  input  logic [23:0] push_addr_i,
  output logic        ready_o,
  output logic        valid_o,
  output logic        ram_wr_o,
  output logic [23:0] ram_addr_o,
  output logic [15:0] ram_wdata_o,
  input  logic        ram_ack_i
);

  logic [7:0]  lo_q, lo_d;
  logic [7:0]  hi_q, hi_d;
  logic        valid_q, valid_d;
  logic [23:0] addr_q, addr_d;
  logic [15:0] data_q, data_d;

  // A word acknowledged this cycle frees the slot on the same edge, so a
  // pending push can reuse it and ram_wr stays high without a bubble.
  assign ready_o = ~valid_q | ram_ack_i;

  always_comb begin
    lo_d    = lo_q;
    hi_d    = hi_q;
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    if (lo_we_i) lo_d = byte_i;
    if (hi_we_i) hi_d = byte_i;
    if (push_i && ready_o) begin
      valid_d = 1'b1;
      addr_d  = push_addr_i;
      data_d  = {hi_q, lo_q};
    end else if (valid_q && ram_ack_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      lo_q    <= 8'h00;
      hi_q    <= 8'h00;
      valid_q <= 1'b0;
      addr_q  <= 24'h00_0000;
      data_q  <= 16'h0000;
    end else begin
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign valid_o     = valid_q;
  assign ram_wr_o    = valid_q;
  assign ram_addr_o  = addr_q;
  assign ram_wdata_o = data_q;

endmodule

// File: rtl/bios_loader.sv
// Boot-time copy sequencer: moves the BIOS image, and optionally the MEGA
// ROM image, from flash into SD-RAM, packing bytes into 16-bit words and
// overlapping flash fetches with SD-RAM writes.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   start, mega_en        : begin a copy; mega_en sampled with start
//   busy, done            : copy in progress / completed
//   flash_rd, flash_addr, flash_ack, flash_data : flash byte read port
//   ram_wr, ram_addr, ram_wdata, ram_ack        : SD-RAM word write port
module bios_loader
  import bios_loader_pkg::*;
#(
  parameter logic [23:0] BIOS_SRC  = FLASH_ADDR_BIOS,
  parameter logic [23:0] BIOS_DST  = RAM_ADDR_BIOS,
  parameter logic [23:0] BIOS_SIZE = FLASH_SIZE_BIOS,
  parameter logic [23:0] MEGA_SRC  = FLASH_ADDR_MEGAROM,
  parameter logic [23:0] MEGA_DST  = RAM_ADDR_MEGAROM,
  parameter logic [23:0] MEGA_SIZE = FLASH_SIZE_MEGAROM
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        mega_en,
  output logic        busy,
  output logic        done,
  output logic        flash_rd,
  output logic [23:0] flash_addr,
  input  logic        flash_ack,
  input  logic [7:0]  flash_data,
  output logic        ram_wr,
  output logic [23:0] ram_addr,
  output logic [15:0] ram_wdata,
  input  logic        ram_ack
);

  localparam logic [WordCntW-1:0] BiosWords = size_to_words(BIOS_SIZE);
  localparam logic [WordCntW-1:0] MegaWords = size_to_words(MEGA_SIZE);

  state_e              state_q, state_d;
  phase_e              phase_q, phase_d;
  logic                mega_q, mega_d;
  logic                done_q, done_d;
  logic [23:0]         src_q, src_d;
  logic [23:0]         dst_q, dst_d;
  logic [WordCntW-1:0] wcnt_q, wcnt_d;

  logic lo_we, hi_we, push;
  logic buf_ready, buf_valid;
  logic last_write_done;

  // The copy is finished once nothing is buffered or the buffered word is
  // being acknowledged right now.
  assign last_write_done = ~buf_valid | ram_ack;

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    mega_d  = mega_q;
    done_d  = done_q;
    src_d   = src_q;
    dst_d   = dst_q;
    wcnt_d  = wcnt_q;
    lo_we   = 1'b0;
    hi_we   = 1'b0;
    push    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          mega_d  = mega_en;
          phase_d = PHASE_BIOS;
          src_d   = BIOS_SRC;
          dst_d   = BIOS_DST;
          wcnt_d  = BiosWords;
          done_d  = 1'b0;
          // An empty BIOS phase goes straight to the phase switch.
          state_d = (BiosWords == '0) ? StNext : StFetchLo;
        end
      end
      StFetchLo: begin
        if (flash_ack) begin
          lo_we   = 1'b1;
          src_d   = src_q + 24'd1;
          state_d = StFetchHi;
        end
      end
      StFetchHi: begin
        if (flash_ack) begin
          hi_we   = 1'b1;
          src_d   = src_q + 24'd1;
          state_d = StPush;
        end
      end
      StPush: begin
        push = 1'b1;
        if (buf_ready) begin
          dst_d   = dst_q + 24'd2;
          state_d = StNext;
        end
      end
      StNext: begin
        if (wcnt_q > 21'd1) begin
          wcnt_d  = wcnt_q - 21'd1;
          state_d = StFetchLo;
        end else if (phase_q == PHASE_BIOS && mega_q && MegaWords != '0) begin
          phase_d = PHASE_MEGA;
          src_d   = MEGA_SRC;
          dst_d   = MEGA_DST;
          wcnt_d  = MegaWords;
          state_d = StFetchLo;
        end else if (last_write_done) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end else begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (last_write_done) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      phase_q <= PHASE_BIOS;
      mega_q  <= 1'b0;
      done_q  <= 1'b0;
      src_q   <= 24'h00_0000;
      dst_q   <= 24'h00_0000;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      mega_q  <= mega_d;
      done_q  <= done_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      wcnt_q  <= wcnt_d;
    end
  end

  assign busy       = (state_q != StIdle);
  assign done       = done_q;
  assign flash_rd   = (state_q == StFetchLo) || (state_q == StFetchHi);
  assign flash_addr = src_q;

  bios_loader_word_pack_buf u_word_pack_buf (
    .clk_i       (clk),
    .reset_i     (reset),
    .lo_we_i     (lo_we),
    .hi_we_i     (hi_we),
    .byte_i      (flash_data),
    .push_i      (push),
    .push_addr_i (dst_q),
    .ready_o     (buf_ready),
    .valid_o     (buf_valid),
    .ram_wr_o    (ram_wr),
    .ram_addr_o  (ram_addr),
    .ram_wdata_o (ram_wdata),
    .ram_ack_i   (ram_ack)
  );

endmodule

// File: tb/tb_bios_loader.sv
// Directed bench for bios_loader using shrunken images so full copies stay
// short: BIOS 0x100 bytes (128 words), MEGA 0x40 bytes (32 words).
module tb_bios_loader;

  localparam logic [23:0] BIOS_SRC  = 24'h10_0000;
  localparam logic [23:0] BIOS_DST  = 24'h70_0000;
  localparam logic [23:0] BIOS_SIZE = 24'h00_0100;
  localparam logic [23:0] MEGA_SRC  = 24'h20_0000;
  localparam logic [23:0] MEGA_DST  = 24'h40_0000;
  localparam logic [23:0] MEGA_SIZE = 24'h00_0040;
  localparam int BIOS_WORDS = 128;
  localparam int MEGA_WORDS = 32;
  localparam int BUDGET     = 20000;

  logic        clk;
  logic        reset;
  logic        start;
  logic        mega_en;
  logic        busy;
  logic        done;
  logic        flash_rd;
  logic [23:0] flash_addr;
  logic        flash_ack;
  logic [7:0]  flash_data;
  logic        ram_wr;
  logic [23:0] ram_addr;
  logic [15:0] ram_wdata;
  logic        ram_ack;

  int checks;
  int failures;
  int flash_lat;
  int ram_lat;
  int flash_cnt;
  logic [23:0] wr_addr_log[$];
  logic [15:0] wr_data_log[$];

  bios_loader #(
    .BIOS_SRC  (BIOS_SRC),
    .BIOS_DST  (BIOS_DST),
    .BIOS_SIZE (BIOS_SIZE),
    .MEGA_SRC  (MEGA_SRC),
    .MEGA_DST  (MEGA_DST),
    .MEGA_SIZE (MEGA_SIZE)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .mega_en    (mega_en),
    .busy       (busy),
    .done       (done),
    .flash_rd   (flash_rd),
    .flash_addr (flash_addr),
    .flash_ack  (flash_ack),
    .flash_data (flash_data),
    .ram_wr     (ram_wr),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_ack    (ram_ack)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Flash contents: two fixed bytes for the first word, a hash elsewhere.
  function automatic logic [7:0] fb(input logic [23:0] a);
    if (a == 24'h10_0000) return 8'h34;
    if (a == 24'h10_0001) return 8'h12;
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5A;
  endfunction

  // Flash responder: ack flash_lat cycles after the request is seen.
  initial begin
    int cnt;
    cnt = 0;
    flash_ack = 1'b0;
    flash_data = 8'h00;
    forever begin
      @(negedge clk);
      if (flash_ack) begin
        flash_ack = 1'b0;
        cnt = 0;
      end else if (flash_rd) begin
        cnt++;
        if (cnt > flash_lat) begin
          flash_ack = 1'b1;
          flash_data = fb(flash_addr);
          flash_cnt++;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // SD-RAM responder: ack ram_lat cycles after the request, logging writes.
  initial begin
    int cnt;
    cnt = 0;
    ram_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (ram_ack) begin
        ram_ack = 1'b0;
        cnt = 0;
      end else if (ram_wr) begin
        cnt++;
        if (cnt > ram_lat) begin
          ram_ack = 1'b1;
          wr_addr_log.push_back(ram_addr);
          wr_data_log.push_back(ram_wdata);
        end
      end else begin
        cnt = 0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    wr_addr_log.delete();
    wr_data_log.delete();
    flash_cnt = 0;
  endtask

  // Pulse start and check the first-cycle response; optionally re-pulse
  // start mid-copy with the opposite mega_en; then wait for done.
  task automatic run_copy(input logic mega, input int fl, input int rl, input logic poke);
    logic timed_out;
    flash_lat = fl;
    ram_lat = rl;
    clear_logs();
    @(negedge clk);
    start = 1'b1;
    mega_en = mega;
    @(posedge clk);
    #1;
    check("start_busy", {31'd0, busy}, 32'd1);
    check("start_flash_rd", {31'd0, flash_rd}, 32'd1);
    check("start_flash_addr", {8'd0, flash_addr}, {8'd0, BIOS_SRC});
    check("start_done_clr", {31'd0, done}, 32'd0);
    @(negedge clk);
    start = 1'b0;
    mega_en = 1'b0;
    if (poke) begin
      repeat (60) @(negedge clk);
      start = 1'b1;
      mega_en = ~mega;
      @(negedge clk);
      start = 1'b0;
      mega_en = 1'b0;
    end
    timed_out = 1'b1;
    for (int i = 0; i < BUDGET; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        timed_out = 1'b0;
        break;
      end
    end
    check("done_timeout", {31'd0, timed_out}, 32'd0);
    check("end_busy", {31'd0, busy}, 32'd0);
    check("end_done", {31'd0, done}, 32'd1);
  endtask

  // Scoreboard: every word in order, none lost or duplicated.
  task automatic verify(input logic mega);
    int n;
    int m;
    logic [23:0] ea;
    logic [23:0] sa;
    n = BIOS_WORDS + (mega ? MEGA_WORDS : 0);
    check("write_count", wr_addr_log.size(), n);
    check("flash_reads", flash_cnt, 2 * n);
    m = (wr_addr_log.size() < n) ? wr_addr_log.size() : n;
    for (int i = 0; i < m; i++) begin
      if (i < BIOS_WORDS) begin
        ea = BIOS_DST + 24'(2 * i);
        sa = BIOS_SRC + 24'(2 * i);
      end else begin
        ea = MEGA_DST + 24'(2 * (i - BIOS_WORDS));
        sa = MEGA_SRC + 24'(2 * (i - BIOS_WORDS));
      end
      check("wr_addr", {8'd0, wr_addr_log[i]}, {8'd0, ea});
      check("wr_data", {16'd0, wr_data_log[i]}, {16'd0, fb(sa + 24'd1), fb(sa)});
    end
    if (m > 0) begin
      check("first_addr", {8'd0, wr_addr_log[0]}, 32'h0070_0000);
      check("first_data", {16'd0, wr_data_log[0]}, 32'h0000_1234);
      check("last_addr", {8'd0, wr_addr_log[m-1]}, mega ? 32'h0040_003E : 32'h0070_00FE);
    end
  endtask

  initial begin
    logic timed_out;
    checks = 0;
    failures = 0;
    flash_lat = 1;
    ram_lat = 2;
    flash_cnt = 0;
    reset = 1'b1;
    start = 1'b0;
    mega_en = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_flash_rd", {31'd0, flash_rd}, 32'd0);
    check("rst_ram_wr", {31'd0, ram_wr}, 32'd0);
    check("rst_flash_addr", {8'd0, flash_addr}, 32'd0);
    check("rst_ram_addr", {8'd0, ram_addr}, 32'd0);
    check("rst_ram_wdata", {16'd0, ram_wdata}, 32'd0);

    // BIOS only, fast peers.
    run_copy(1'b0, 1, 2, 1'b0);
    verify(1'b0);

    // BIOS + MEGA with slow SD-RAM and a stray start while busy.
    run_copy(1'b1, 1, 20, 1'b1);
    verify(1'b1);

    // Reset during word 100.
    flash_lat = 1;
    ram_lat = 2;
    clear_logs();
    @(negedge clk);
    start = 1'b1;
    mega_en = 1'b0;
    @(negedge clk);
    start = 1'b0;
    timed_out = 1'b1;
    for (int i = 0; i < BUDGET; i++) begin
      @(negedge clk);
      if (wr_addr_log.size() >= 100) begin
        timed_out = 1'b0;
        break;
      end
    end
    check("word100_timeout", {31'd0, timed_out}, 32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_flash_rd", {31'd0, flash_rd}, 32'd0);
    check("midrst_ram_wr", {31'd0, ram_wr}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_flash_addr", {8'd0, flash_addr}, 32'd0);

    // start together with reset: reset wins, stays idle.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("rst_start_busy", {31'd0, busy}, 32'd0);
    check("rst_start_flash_rd", {31'd0, flash_rd}, 32'd0);
    check("rst_start_done", {31'd0, done}, 32'd0);

    // Restart after the abandoned copy.
    run_copy(1'b0, 1, 2, 1'b0);
    verify(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
